// File: rtl/matvec_engine_if.sv
// Avalon-MM read-master bus used by matvec_engine to fetch the B vector and the rows of A.
interface matvec_engine_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WORD_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_read;
  logic [WORD_WIDTH-1:0] mem_readdata;
  logic                  mem_readdatavalid;
  logic                  mem_waitrequest;

  modport master (
    output mem_address,
    output mem_read,
    input  mem_readdata,
    input  mem_readdatavalid,
    input  mem_waitrequest
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    output mem_readdata,
    output mem_readdatavalid,
    output mem_waitrequest
  );
endinterface

// File: rtl/matvec_engine.sv
// Matrix-vector engine: fetches B then the ROWS rows of A, then accumulates C = A x B column by
// column. Define MATVEC_SIGNED_EN for two's-complement elements; the default build is unsigned.
module matvec_engine #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 8,
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  output logic                      busy,
  output logic                      done,
  output logic [ROWS*ACC_WIDTH-1:0] result,
  matvec_engine_if.master           mem
);

  localparam int unsigned WORD_WIDTH = COLS * DATA_WIDTH;
  localparam int unsigned WCNT_WIDTH = $clog2(ROWS + 1) + 1;
  localparam int unsigned KCNT_WIDTH = $clog2(COLS + 1);

  typedef enum logic [1:0] {StIdle, StFetch, StCalc, StDone} state_e;

  state_e                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]           base_q, base_d;
  logic [WCNT_WIDTH-1:0]           word_cnt_q, word_cnt_d;
  logic [KCNT_WIDTH-1:0]           col_cnt_q, col_cnt_d;
  logic                            outstanding_q, outstanding_d;
  logic [WORD_WIDTH-1:0]           b_q, b_d;
  logic [ROWS-1:0][WORD_WIDTH-1:0] a_q, a_d;
  logic [ROWS-1:0][ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ROWS-1:0][ACC_WIDTH-1:0]  prod_ext;

  logic [WORD_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] b_el;
  logic                  read_req;
  logic                  accept;
  logic                  capture;

  assign rdata    = mem.mem_readdata;
  assign read_req = (state_q == StFetch) && !outstanding_q;
  assign accept   = read_req && !mem.mem_waitrequest;
  // A response only counts against an accepted read; stray or post-reset ones fall through.
  assign capture  = (state_q == StFetch) && mem.mem_readdatavalid && (outstanding_q || accept);

  assign b_el = DATA_WIDTH'(b_q >> (DATA_WIDTH * 32'(col_cnt_q)));

  always_comb begin
    logic [DATA_WIDTH-1:0] a_el;
`ifdef MATVEC_SIGNED_EN
    logic signed [2*DATA_WIDTH-1:0] a_s;
    logic signed [2*DATA_WIDTH-1:0] b_s;
    logic signed [2*DATA_WIDTH-1:0] p_s;
`else
    logic [2*DATA_WIDTH-1:0] p_u;
`endif
    prod_ext = '0;
    for (int r = 0; r < ROWS; r++) begin
      a_el = DATA_WIDTH'(a_q[r] >> (DATA_WIDTH * 32'(col_cnt_q)));
`ifdef MATVEC_SIGNED_EN
      a_s = (2*DATA_WIDTH)'($signed(a_el));
      b_s = (2*DATA_WIDTH)'($signed(b_el));
      p_s = a_s * b_s;
      prod_ext[r] = ACC_WIDTH'(p_s);
`else
      p_u = (2*DATA_WIDTH)'(a_el) * (2*DATA_WIDTH)'(b_el);
      prod_ext[r] = ACC_WIDTH'(p_u);
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    word_cnt_d    = word_cnt_q;
    col_cnt_d     = col_cnt_q;
    outstanding_d = outstanding_q;
    b_d           = b_q;
    a_d           = a_q;
    acc_d         = acc_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d        = base_addr;
          word_cnt_d    = '0;
          col_cnt_d     = '0;
          outstanding_d = 1'b0;
          acc_d         = '0;
          state_d       = StFetch;
        end
      end
      StFetch: begin
        if (capture) begin
          outstanding_d = 1'b0;
          if (word_cnt_q == '0) begin
            b_d = rdata;
          end
          for (int r = 0; r < ROWS; r++) begin
            if (word_cnt_q == WCNT_WIDTH'(r + 1)) a_d[r] = rdata;
          end
          word_cnt_d = word_cnt_q + WCNT_WIDTH'(1);
          if (word_cnt_q == WCNT_WIDTH'(ROWS)) state_d = StCalc;
        end else if (accept) begin
          outstanding_d = 1'b1;
        end
      end
      StCalc: begin
        for (int r = 0; r < ROWS; r++) begin
          acc_d[r] = acc_q[r] + prod_ext[r];
        end
        col_cnt_d = col_cnt_q + KCNT_WIDTH'(1);
        if (col_cnt_q == KCNT_WIDTH'(COLS - 1)) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      base_q        <= '0;
      word_cnt_q    <= '0;
      col_cnt_q     <= '0;
      outstanding_q <= 1'b0;
      b_q           <= '0;
      a_q           <= '0;
      acc_q         <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      word_cnt_q    <= word_cnt_d;
      col_cnt_q     <= col_cnt_d;
      outstanding_q <= outstanding_d;
      b_q           <= b_d;
      a_q           <= a_d;
      acc_q         <= acc_d;
    end
  end

  assign busy            = (state_q == StFetch) || (state_q == StCalc);
  assign done            = (state_q == StDone);
  assign result          = acc_q;
  assign mem.mem_read    = read_req;
  assign mem.mem_address = base_q + ADDR_WIDTH'(word_cnt_q);

endmodule
